idct4x4_seq: RTL and testbench
==============================

Name: idct4x4_seq

Overview:
- Sequential 4x4 2-D inverse integer transform around the 1-D butterfly core `dct_inv`.
- Accepts one dequantised coefficient row per handshake beat and runs the row pass on entry.
- Stores row results in a transpose buffer, then runs the column pass one column per cycle.
- Applies final rounding and drains the residual block in raster row order to the reconstruction stage.

Parameters:
- IN_W, 13, coefficient and intermediate width (signed); matches the `dct_inv` datapath.
- OUT_W, 9, output residual width (signed). Must be >= 8 with IDCT_ROUND_EN defined, and exactly 13 without it.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_row holds a valid coefficient row.
- in_ready  output  1  block accepts a row this cycle.
- in_row[4]  input  IN_W each, signed  coefficient row, index 0..3 = columns 0..3.
- out_valid  output  1  out_row holds a valid residual row.
- out_ready  input  1  downstream accepts out_row.
- out_row[4]  output  OUT_W each, signed  residual row, raster order.
- out_last  output  1  high with the 4th (final) row of a block.

Behaviour:
- Reset values (async on rst_n low, held until release): state=LOAD, row_cnt=0, col_cnt=0, drain_cnt=0, in_ready=1, out_valid=0, out_last=0. Buffers are not reset; out_row is don't-care while out_valid=0.
- FSM states are LOAD, COL and DRAIN.
- LOAD:
  - in_ready=1.
  - A beat is accepted when in_valid&&in_ready.
  - On a beat, in_row passes through a combinational `dct_inv` instance (row pass) and the result is written to tbuf[row_cnt][0..3], then row_cnt++.
  - On the 4th beat: row_cnt wraps to 0 and the next state is COL.
  - No beat: state holds.
- COL:
  - in_ready=0.
  - Each cycle, column col_cnt (tbuf[0..3][col_cnt]) feeds a second `dct_inv` instance.
  - Its four outputs pass through the rounding stage and are written to rbuf[0..3][col_cnt], then col_cnt++.
  - After col_cnt=3 the next state is DRAIN.
  - The state takes exactly 4 cycles and does not stall.
- DRAIN:
  - out_valid=1 and out_row=rbuf[drain_cnt]; outputs come directly from registers.
  - out_last=(drain_cnt==3).
  - On out_valid&&out_ready: drain_cnt++. After the beat with drain_cnt=3, drain_cnt wraps to 0 and the next state is LOAD.
  - While out_ready=0, out_row, out_last and drain_cnt hold stable.
- Latency: if the last input beat is accepted at edge T, out_valid rises after edge T+4, so the first output beat is at edge T+5.
- Throughput: 12 cycles per block minimum (4 LOAD + 4 COL + 4 DRAIN); blocks do not overlap.
- Arithmetic:
  - Butterfly sums are IN_W-bit signed and wrap modulo 2^IN_W; there is no saturation.
  - `>>>1` is arithmetic (floor).
- Rounding (IDCT_ROUND_EN defined): r = (v + 32) >>> 6. Compute it at IN_W+1 bits, then sign-extend to OUT_W. Range is -64..64, so there is no clipping.
- in_valid asserted outside LOAD is ignored; the upstream stage holds it, per the handshake.
- Reset mid-operation aborts the partial block. After release the block is in LOAD with row_cnt=0, and the first beat starts a new block.

Optional Feature:
- IDCT_ROUND_EN defined: final (v+32)>>>6 rounding is applied in the COL state.
- IDCT_ROUND_EN undefined:
  - Raw column-pass results are written to rbuf unmodified and OUT_W must be 13; an elaboration-time check fails otherwise.
  - Timing and the handshake are identical.

Test Plan:
- DC only: row0=[640,0,0,0], rows1-3=0, out_ready=1 -> 4 beats each [10,10,10,10]; out_last on beat 4; first beat 5 cycles after last input.
- Odd path: row0=[0,64,0,0], rows1-3=0 -> every output row [1,1,0,-1]. With IDCT_ROUND_EN undefined -> every row [64,32,-32,-64].
- Backpressure: drop out_ready for 10 cycles after the first output beat -> out_valid stays 1, out_row and out_last stay stable, in_ready=0; the remaining 3 rows follow in order after release.
- Reset mid-block: accept 2 rows, pulse rst_n low -> out_valid=0 and in_ready=1 immediately; the next full DC block (640) yields all 10s with no residue from the aborted rows.
- Back-to-back: in_valid and out_ready held high, 3 distinct blocks -> one block per 12 cycles, in_ready low for exactly 8 cycles between blocks, outputs match a golden model.
- Wrap: row0=[4095,4095,0,0] -> results match a 13-bit wrapping golden model (no saturation); no X on out_row during DRAIN.

Source files
------------

// File: rtl/idct4x4_seq.sv
// Sequential 4x4 inverse integer transform: row pass on entry, column pass from a transpose buffer, raster drain.
// Optional define IDCT_ROUND_EN enables the final (v+32)>>>6 rounding (OUT_W >= 8); without it OUT_W must be 13.

module dct_inv #(
    parameter int IN_W = 13
) (
    input  logic signed [IN_W-1:0] x [4],
    output logic signed [IN_W-1:0] y [4]
);
    logic signed [IN_W-1:0] e0, e1, e2, e3;

    // Even/odd butterfly; every sum wraps at IN_W bits.
    always_comb begin
        e0   = x[0] + x[2];
        e1   = x[0] - x[2];
        e2   = (x[1] >>> 1) - x[3];
        e3   = x[1] + (x[3] >>> 1);
        y[0] = e0 + e3;
        y[1] = e1 + e2;
        y[2] = e1 - e2;
        y[3] = e0 - e3;
    end
endmodule

module idct4x4_seq #(
    parameter int IN_W  = 13,
`ifdef IDCT_ROUND_EN
    parameter int OUT_W = 9
`else
    parameter int OUT_W = 13
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_row [4],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_row [4],
    output logic                    out_last
);
`ifdef IDCT_ROUND_EN
    if (OUT_W < 8) begin : g_bad_out_w
        $error("idct4x4_seq: OUT_W must be >= 8 when rounding is enabled");
    end
`else
    if (OUT_W != 13) begin : g_bad_out_w
        $error("idct4x4_seq: OUT_W must be 13 when rounding is disabled");
    end
`endif

    typedef enum logic [1:0] {LOAD, COL, DRAIN} state_t;

    state_t                  state, state_nx;
    logic [1:0]              row_cnt, col_cnt, drain_cnt;
    logic signed [IN_W-1:0]  tbuf [4][4];
    logic signed [OUT_W-1:0] rbuf [4][4];
    logic signed [IN_W-1:0]  row_y [4];
    logic signed [IN_W-1:0]  col_x [4];
    logic signed [IN_W-1:0]  col_y [4];
    logic                    load_fire, drain_fire;

    function automatic logic signed [OUT_W-1:0] fin_scale(input logic signed [IN_W-1:0] v);
`ifdef IDCT_ROUND_EN
        logic signed [IN_W:0] s;
        s = (IN_W+1)'(v) + (IN_W+1)'(32);
        return OUT_W'(s >>> 6);
`else
        return OUT_W'(v);
`endif
    endfunction

    assign load_fire  = in_valid && in_ready;
    assign drain_fire = out_valid && out_ready;

    dct_inv #(.IN_W(IN_W)) u_row (.x(in_row), .y(row_y));

    always_comb begin
        for (int r = 0; r < 4; r++) col_x[r] = tbuf[r][col_cnt];
    end

    dct_inv #(.IN_W(IN_W)) u_col (.x(col_x), .y(col_y));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            row_cnt   <= 2'd0;
            col_cnt   <= 2'd0;
            drain_cnt <= 2'd0;
        end else begin
            state <= state_nx;
            if (load_fire)     row_cnt   <= row_cnt + 2'd1;
            if (state == COL)  col_cnt   <= col_cnt + 2'd1;
            if (drain_fire)    drain_cnt <= drain_cnt + 2'd1;
        end
    end

    // Row pass lands in tbuf on entry; column pass lands in rbuf one column per cycle.
    always_ff @(posedge clk) begin
        if (load_fire) begin
            for (int c = 0; c < 4; c++) tbuf[row_cnt][c] <= row_y[c];
        end
        if (state == COL) begin
            for (int r = 0; r < 4; r++) rbuf[r][col_cnt] <= fin_scale(col_y[r]);
        end
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && row_cnt == 2'd3) state_nx = COL;
            end
            COL: begin
                if (col_cnt == 2'd3) state_nx = DRAIN;
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_last  = (drain_cnt == 2'd3);
                if (out_ready && drain_cnt == 2'd3) state_nx = LOAD;
            end
            default: state_nx = LOAD;
        endcase
    end

    always_comb begin
        for (int c = 0; c < 4; c++) out_row[c] = rbuf[drain_cnt][c];
    end
endmodule

// File: tb/tb_idct4x4_seq.sv
// Directed bench for idct4x4_seq with a scoreboard of expected residual rows; honours IDCT_ROUND_EN.
module tb_idct4x4_seq;
    localparam int IN_W = 13;
`ifdef IDCT_ROUND_EN
    localparam int OUT_W = 9;
`else
    localparam int OUT_W = 13;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [IN_W-1:0]  in_row [4];
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_row [4];
    logic                    out_last;

    idct4x4_seq #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row), .out_last(out_last)
    );

    always #5 clk = ~clk;

    typedef struct { int v[4]; bit last; } exp_t;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cur [4][4];
    int   strm [12][4];

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int w13(int v);
        int t;
        t = v & 8191;
        return (t >= 4096) ? t - 8192 : t;
    endfunction

    function automatic int fin(int v);
`ifdef IDCT_ROUND_EN
        return (v + 32) >>> 6;
`else
        return v;
`endif
    endfunction

    // Reference 1-D transform written in direct matrix form.
    task automatic push_block();
        int rr [4][4];
        int a, b, c, d;
        exp_t e;
        for (int r = 0; r < 4; r++) begin
            a = cur[r][0]; b = cur[r][1]; c = cur[r][2]; d = cur[r][3];
            rr[r][0] = w13(a + b + c + (d >>> 1));
            rr[r][1] = w13(a + (b >>> 1) - c - d);
            rr[r][2] = w13(a - (b >>> 1) - c + d);
            rr[r][3] = w13(a - b + c - (d >>> 1));
        end
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < 4; k++) begin
                a = rr[0][k]; b = rr[1][k]; c = rr[2][k]; d = rr[3][k];
                case (r)
                    0: e.v[k] = fin(w13(a + b + c + (d >>> 1)));
                    1: e.v[k] = fin(w13(a + (b >>> 1) - c - d));
                    2: e.v[k] = fin(w13(a - (b >>> 1) - c + d));
                    default: e.v[k] = fin(w13(a - b + c - (d >>> 1)));
                endcase
            end
            e.last = (r == 3);
            sb.push_back(e);
        end
    endtask

    task automatic push_const(input int a, input int b, input int c, input int d);
        exp_t e;
        e.v[0] = a; e.v[1] = b; e.v[2] = c; e.v[3] = d;
        for (int r = 0; r < 4; r++) begin
            e.last = (r == 3);
            sb.push_back(e);
        end
    endtask

    task automatic set_cur(input int r, input int a, input int b, input int c, input int d);
        cur[r][0] = a; cur[r][1] = b; cur[r][2] = c; cur[r][3] = d;
    endtask

    // Called at a negedge; returns at the negedge after the last accepting edge.
    task automatic send_rows(input int nrows);
        for (int r = 0; r < nrows; r++) begin
            int guard = 0;
            while (!in_ready && guard < 50) begin @(negedge clk); guard++; end
            if (guard >= 50) chk("send_timeout", 0, 1);
            in_valid = 1'b1;
            for (int c = 0; c < 4; c++) in_row[c] = IN_W'(cur[r][c]);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic recv_block(input int stall, output int lat);
        exp_t e;
        lat = 0;
        for (int b = 0; b < 4; b++) begin
            int guard = 0;
            while (!out_valid && guard < 50) begin @(negedge clk); guard++; end
            if (b == 0) lat = guard;
            if (guard >= 50 || sb.size() == 0) begin
                chk("recv_timeout", 0, 1);
                return;
            end
            e = sb.pop_front();
            for (int c = 0; c < 4; c++) chk($sformatf("row%0d_col%0d", b, c), out_row[c], e.v[c]);
            chk($sformatf("last%0d", b), out_last, e.last);
            @(negedge clk);
            if (b == 0 && stall > 0) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall; s++) begin
                    chk("bp_valid", out_valid, 1);
                    chk("bp_in_ready", in_ready, 0);
                    chk("bp_last", out_last, sb[0].last);
                    for (int c = 0; c < 4; c++) chk("bp_row", out_row[c], sb[0].v[c]);
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        end
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
    endtask

    initial begin
        int lat;
        int idx, low_run, nruns, guard;
        exp_t e;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 4; c++) in_row[c] = '0;
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // DC block with latency check
        set_cur(0, 640, 0, 0, 0); set_cur(1, 0, 0, 0, 0); set_cur(2, 0, 0, 0, 0); set_cur(3, 0, 0, 0, 0);
        send_rows(4);
`ifdef IDCT_ROUND_EN
        push_const(10, 10, 10, 10);
`else
        push_const(640, 640, 640, 640);
`endif
        recv_block(0, lat);
        chk("dc_latency", lat, 4);

        // Odd path
        set_cur(0, 0, 64, 0, 0);
        send_rows(4);
`ifdef IDCT_ROUND_EN
        push_const(1, 1, 0, -1);
`else
        push_const(64, 32, -32, -64);
`endif
        recv_block(0, lat);

        // Backpressure on a mixed block
        set_cur(0, 100, -50, 20, 7); set_cur(1, -30, 12, 0, 5);
        set_cur(2, 8, 8, -8, -8);    set_cur(3, 1, 2, 3, 4);
        send_rows(4);
        push_block();
        recv_block(10, lat);

        // Reset mid-block aborts the partial rows
        set_cur(0, 2000, -1500, 900, 300); set_cur(1, 700, 700, -700, 100);
        send_rows(2);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_cur(0, 640, 0, 0, 0); set_cur(1, 0, 0, 0, 0); set_cur(2, 0, 0, 0, 0); set_cur(3, 0, 0, 0, 0);
        send_rows(4);
`ifdef IDCT_ROUND_EN
        push_const(10, 10, 10, 10);
`else
        push_const(640, 640, 640, 640);
`endif
        recv_block(0, lat);

        // Wrap without saturation
        set_cur(0, 4095, 4095, 0, 0);
        send_rows(4);
`ifdef IDCT_ROUND_EN
        push_const(0, -32, 32, 0);
`else
        push_const(-2, -2050, 2048, 0);
`endif
        recv_block(0, lat);

        // Back-to-back: three blocks with in_valid and out_ready held high
        for (int r = 0; r < 12; r++)
            for (int c = 0; c < 4; c++) strm[r][c] = int'($urandom_range(4000)) - 2000;
        idx = 0; low_run = 0; nruns = 0; guard = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 4; c++) in_row[c] = IN_W'(strm[0][c]);
        while (guard < 200) begin
            bit accept;
            guard++;
            if (!in_ready) low_run++;
            else if (low_run > 0) begin
                chk("b2b_gap", low_run, 8);
                nruns++;
                low_run = 0;
            end
            if (idx == 12 && sb.size() == 0 && in_ready) break;
            accept = in_valid && in_ready;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) chk("b2b_extra_beat", 0, 1);
                else begin
                    e = sb.pop_front();
                    for (int c = 0; c < 4; c++) chk("b2b_row", out_row[c], e.v[c]);
                    chk("b2b_last", out_last, e.last);
                end
            end
            @(negedge clk);
            if (accept) begin
                idx++;
                if (idx % 4 == 0) begin
                    for (int r = 0; r < 4; r++)
                        for (int c = 0; c < 4; c++) cur[r][c] = strm[idx - 4 + r][c];
                    push_block();
                end
                if (idx < 12) for (int c = 0; c < 4; c++) in_row[c] = IN_W'(strm[idx][c]);
                else in_valid = 1'b0;
            end
        end
        if (guard >= 200) chk("b2b_timeout", 0, 1);
        chk("b2b_gap_count", nruns, 3);
        chk("b2b_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
